// File: rtl/inst_encode_writer_pkg.sv
// Shared definitions for the instruction encode writer: immSrc format codes,
// error causes and FSM states.
package inst_encode_writer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IMM_I_LOAD  = 3'b000,
    IMM_I_ALU   = 3'b001,
    IMM_I_SHAMT = 3'b010,
    IMM_S       = 3'b011,
    IMM_U       = 3'b100,
    IMM_B       = 3'b101,
    IMM_I_JALR  = 3'b110,
    IMM_J       = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/inst_encode_writer_if.sv
// Request and instruction-memory write bus of the encode writer.
interface inst_encode_writer_if;
  import inst_encode_writer_pkg::*;

  logic            valid;
  logic            ready;
  logic [2:0]      imm_src;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] base;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;

  modport writer (
    input  valid, imm_src, imm, base, mem_ready,
    output ready, mem_we, mem_addr, mem_wdata
  );

  modport host (
    output valid, imm_src, imm, base, mem_ready,
    input  ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/inst_encode_writer_imm_pack.sv
// Combinational packer: scatters an immediate into RV32I instruction fields
// and reports range/alignment violations (range wins).
module inst_encode_writer_imm_pack
  import inst_encode_writer_pkg::*;
(
  input  logic [2:0]      imm_src_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] base_i,
  output logic [XLEN-1:0] inst_c_o,
  output logic [1:0]      err_code_c_o
);

  logic range_bad_c;
  logic align_bad_c;

  always_comb begin
    inst_c_o    = base_i;
    range_bad_c = 1'b0;
    align_bad_c = 1'b0;
    case (imm_src_e'(imm_src_i))
      IMM_I_LOAD, IMM_I_ALU, IMM_I_JALR: begin
        inst_c_o[31:20] = imm_i[11:0];
        range_bad_c     = imm_i[31:11] != {21{imm_i[11]}};
      end
      IMM_I_SHAMT: begin
        inst_c_o[24:20] = imm_i[4:0];
        range_bad_c     = imm_i[31:5] != 27'd0;
      end
      IMM_S: begin
        inst_c_o[31:25] = imm_i[11:5];
        inst_c_o[11:7]  = imm_i[4:0];
        range_bad_c     = imm_i[31:11] != {21{imm_i[11]}};
      end
      IMM_U: begin
        inst_c_o[31:12] = imm_i[31:12];
        align_bad_c     = imm_i[11:0] != 12'd0;
      end
      IMM_B: begin
        inst_c_o[31]    = imm_i[12];
        inst_c_o[7]     = imm_i[11];
        inst_c_o[30:25] = imm_i[10:5];
        inst_c_o[11:8]  = imm_i[4:1];
        range_bad_c     = imm_i[31:12] != {20{imm_i[12]}};
        align_bad_c     = imm_i[0];
      end
      IMM_J: begin
        inst_c_o[31]    = imm_i[20];
        inst_c_o[19:12] = imm_i[19:12];
        inst_c_o[20]    = imm_i[11];
        inst_c_o[30:21] = imm_i[10:1];
        range_bad_c     = imm_i[31:20] != {12{imm_i[20]}};
        align_bad_c     = imm_i[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    err_code_c_o = ERR_NONE;
    if (range_bad_c)      err_code_c_o = ERR_RANGE;
    else if (align_bad_c) err_code_c_o = ERR_ALIGN;
  end

endmodule

// File: rtl/inst_encode_writer.sv
// Encodes immediate requests into RV32I words and writes them to instruction
// memory at an auto-incrementing address, tracking fill level and errors.
module inst_encode_writer
  import inst_encode_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  inst_encode_writer_if.writer  bus,
  output logic                  o_full,
  output logic                  o_err,
  output logic [1:0]            o_errCode,
  output logic [CNT_W-1:0]      o_count
);

  state_e           state_q;
  logic             ready_q;
  logic             we_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic             full_q;
  logic             err_q;
  err_e             code_q;
  logic [CNT_W-1:0] count_q;

  logic [XLEN-1:0]  pack_inst_c;
  logic [1:0]       pack_err_c;
  logic [CNT_W-1:0] count_inc_c;
  logic             accept_c;

  inst_encode_writer_imm_pack u_pack (
    .imm_src_i    (bus.imm_src),
    .imm_i        (bus.imm),
    .base_i       (bus.base),
    .inst_c_o     (pack_inst_c),
    .err_code_c_o (pack_err_c)
  );

  assign accept_c    = bus.valid & ready_q;
  assign count_inc_c = count_q + CNT_W'(1);

  // i_start outranks every state action, so a request in that cycle is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      count_q <= '0;
      if (i_rst) wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (err_e'(pack_err_c) == ERR_NONE) begin
              wdata_q <= pack_inst_c;
              we_q    <= 1'b1;
              ready_q <= 1'b0;
              state_q <= ST_WRITE;
            end else begin
              err_q <= 1'b1;
              if (!err_q) code_q <= err_e'(pack_err_c);
            end
          end
        end
        ST_WRITE: begin
          if (bus.mem_ready) begin
            we_q    <= 1'b0;
            addr_q  <= addr_q + XLEN'(4);
            count_q <= count_inc_c;
            if (count_inc_c == CNT_W'(DEPTH)) begin
              full_q  <= 1'b1;
              state_q <= ST_FULL;
            end else begin
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_FULL: ;
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign o_full        = full_q;
  assign o_err         = err_q;
  assign o_errCode     = code_q;
  assign o_count       = count_q;

endmodule

// File: tb/tb_inst_encode_writer.sv
// Scoreboard bench: stimulus queues expected writes, a monitor checks every
// completed memory write (address, data, immediate round-trip, base bits).
module tb_inst_encode_writer;
  import inst_encode_writer_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        full;
  logic        err;
  logic [1:0]  code;
  logic [15:0] count;

  always #5 clk = ~clk;

  inst_encode_writer_if bus ();

  inst_encode_writer #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .bus       (bus),
    .o_full    (full),
    .o_err     (err),
    .o_errCode (code),
    .o_count   (count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] data;
    bit          exact;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_addr = 32'h0;

  function automatic logic [31:0] extend(input logic [2:0] src, input logic [31:0] i);
    case (src)
      3'b010:  return {27'b0, i[24:20]};
      3'b011:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b100:  return {i[31:12], 12'b0};
      3'b101:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b111:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [2:0] src);
    case (src)
      3'b010:         return 32'hFE0F_FFFF;
      3'b011, 3'b101: return 32'h01FF_F07F;
      3'b100, 3'b111: return 32'h0000_0FFF;
      default:        return 32'h000F_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input logic [2:0] src);
    logic [31:0] r;
    r = $urandom;
    case (src)
      3'b010:  return {27'b0, r[4:0]};
      3'b100:  return {r[31:12], 12'b0};
      3'b101:  return {{19{r[12]}}, r[12:1], 1'b0};
      3'b111:  return {{11{r[20]}}, r[20:1], 1'b0};
      default: return {{20{r[11]}}, r[11:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a write completes on any edge where mem_we and mem_ready are both high.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = q.pop_front();
          chk("wr_addr", bus.mem_addr, e.addr);
          if (e.exact) chk("wr_data", bus.mem_wdata, e.data);
          chk("roundtrip", extend(e.src, bus.mem_wdata), e.imm);
          chk("base_bits", bus.mem_wdata & keep_mask(e.src), e.base & keep_mask(e.src));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("ready_timeout", 32'(bus.ready), 32'd1);
        return;
      end
    end
  endtask

  task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                      input bit legal, input bit exact, input logic [31:0] data);
    wait_ready();
    bus.valid   = 1'b1;
    bus.imm_src = src;
    bus.imm     = imm;
    bus.base    = base;
    if (legal) begin
      q.push_back('{exp_addr, src, imm, base, data, exact});
      exp_addr += 32'd4;
    end
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 || bus.mem_we === 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("drain_timeout", 32'(q.size()), 32'd0);
        return;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp_addr = 32'h0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},    32'(bus.mem_we),   32'd0);
    chk({tag, "_addr"},  bus.mem_addr,      32'h0);
    chk({tag, "_wdata"}, bus.mem_wdata,     32'h0);
    chk({tag, "_count"}, 32'(count),        32'd0);
    chk({tag, "_err"},   32'(err),          32'd0);
    chk({tag, "_code"},  32'(code),         32'd0);
    chk({tag, "_full"},  32'(full),         32'd0);
    chk({tag, "_ready"}, 32'(bus.ready),    32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid     = 1'b0;
    bus.imm_src   = 3'b000;
    bus.imm       = 32'h0;
    bus.base      = 32'h0;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    // Back-to-back I-alu writes at consecutive addresses.
    send(3'b001, 32'hFFFF_FFFF, 32'h0000_0093, 1, 1, 32'hFFF0_0093);
    send(3'b001, 32'h0000_0005, 32'h0000_0093, 1, 1, 32'h0050_0093);
    drain();
    chk("count_two", 32'(count), 32'd2);
    chk("addr_two", bus.mem_addr, 32'h8);
    do_start();
    chk("start_count", 32'(count), 32'd0);
    chk("start_addr", bus.mem_addr, 32'h0);

    // B, J, U formats, then illegal requests, then fill to DEPTH.
    send(3'b101, 32'hFFFF_FFFC, 32'h0000_0063, 1, 1, 32'hFE00_0EE3);
    send(3'b111, 32'h0000_0008, 32'h0000_006F, 1, 1, 32'h0080_006F);
    send(3'b100, 32'h1234_5000, 32'h0000_02B7, 1, 1, 32'h1234_52B7);
    send(3'b100, 32'h1234_5001, 32'h0000_02B7, 0, 0, 32'h0);
    chk("align_err", 32'(err), 32'd1);
    chk("align_code", 32'(code), 32'd2);
    send(3'b000, 32'h0000_0800, 32'h0000_0003, 0, 0, 32'h0);
    chk("range_err", 32'(err), 32'd1);
    chk("code_sticky", 32'(code), 32'd2);
    drain();
    chk("count_three", 32'(count), 32'd3);
    send(3'b011, 32'hFFFF_FFF8, 32'h0011_2023, 1, 1, 32'hFE11_2C23);
    drain();
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(bus.ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_addr", bus.mem_addr, 32'h10);
    bus.valid   = 1'b1;
    bus.imm_src = 3'b001;
    bus.imm     = 32'h1;
    bus.base    = 32'h13;
    repeat (3) @(negedge clk);
    bus.valid = 1'b0;
    chk("full_ignored_count", 32'(count), 32'd4);
    chk("full_ignored_we", 32'(bus.mem_we), 32'd0);
    do_start();
    chk("restart_addr", bus.mem_addr, 32'h0);
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_full", 32'(full), 32'd0);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_code", 32'(code), 32'd0);

    // Memory back-pressure: write held stable while mem_ready is low.
    bus.mem_ready = 1'b0;
    send(3'b001, 32'h0000_07FF, 32'h0000_0013, 1, 1, 32'h7FF0_0013);
    for (int i = 0; i < 5; i++) begin
      chk("stall_we", 32'(bus.mem_we), 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h0);
      chk("stall_data", bus.mem_wdata, 32'h7FF0_0013);
      chk("stall_ready", 32'(bus.ready), 32'd0);
      chk("stall_count", 32'(count), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.mem_ready = 1'b1;
    @(negedge clk);
    drain();
    chk("stall_done_count", 32'(count), 32'd1);

    // Request presented together with i_start is not accepted.
    bus.valid   = 1'b1;
    bus.imm_src = 3'b001;
    bus.imm     = 32'h2;
    bus.base    = 32'h13;
    do_start();
    bus.valid = 1'b0;
    chk("start_req_we", 32'(bus.mem_we), 32'd0);
    chk("start_req_count", 32'(count), 32'd0);
    chk("start_req_ready", 32'(bus.ready), 32'd1);

    // i_start abandons a stalled write.
    bus.mem_ready = 1'b0;
    send(3'b001, 32'h3, 32'h13, 1, 1, 32'h0030_0013);
    void'(q.pop_back());
    chk("abandon_we_before", 32'(bus.mem_we), 32'd1);
    do_start();
    chk("abandon_we", 32'(bus.mem_we), 32'd0);
    chk("abandon_count", 32'(count), 32'd0);

    // i_rst drops a stalled write and restores reset values.
    send(3'b001, 32'h4, 32'h13, 1, 1, 32'h0040_0013);
    void'(q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    exp_addr = 32'h0;
    chk_reset_state("midrst");
    bus.mem_ready = 1'b1;

    // Random legal requests across all formats, checked by round-trip.
    for (int k = 0; k < 12; k++) begin
      logic [2:0] src;
      src = 3'(k % 8);
      send(src, rand_imm(src), $urandom, 1, 0, 32'h0);
      if (k % 4 == 3) begin
        drain();
        chk("rand_full", 32'(full), 32'd1);
        do_start();
      end
    end

    drain();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_encode_writer.md
Name: inst_encode_writer

Overview:
Inverse of the immediate extender. Packs a signed/unsigned immediate into the RV32I instruction bit positions selected by the same 3-bit immSrc code, merges it with caller-supplied non-immediate fields, checks range and alignment, and writes the resulting word to instruction memory at an auto-incrementing address. Used by the program loader and self-test sequencer to build instruction streams in hardware.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written after reset/i_start
DEPTH, 1024, maximum words written before the block reports full

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_start  input  1  pulse: reload address to BASE_ADDR, clear count and error
i_valid  input  1  request valid
o_ready  output  1  request accepted when i_valid & o_ready
i_immSrc  input  3  format code: 000 I-load, 001 I-alu, 010 I-shamt, 011 S, 100 U, 101 B, 110 I-jalr, 111 J
i_imm  input  32  immediate value (full-width signed, or byte offset for B/J)
i_base  input  32  opcode/rd/rs1/rs2/funct bits; immediate positions ignored
o_memWe  output  1  write strobe, held until i_memReady
o_memAddr  output  32  word-aligned byte address
o_memWdata  output  32  encoded instruction
i_memReady  input  1  memory accepts write this cycle
o_full  output  1  DEPTH words written
o_err  output  1  sticky: an illegal request was seen
o_errCode  output  2  cause of first error: 01 range, 10 alignment
o_count  output  16  words written since reset/i_start

Behaviour:
- Reset (i_rst high at edge): state IDLE, o_memWe=0, o_memAddr=BASE_ADDR, o_memWdata=0, o_count=0, o_err=0, o_errCode=00, o_full=0; o_ready=1 from the first cycle after reset.
- Packing (inst = i_base with immediate fields overwritten):
  - I (000/001/110): inst[31:20]=imm[11:0]; legal iff imm[31:11] all equal.
  - shamt (010): inst[24:20]=imm[4:0], inst[31:25] from i_base; legal iff imm[31:5]==0.
  - S (011): inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; legal as I.
  - U (100): inst[31:12]=imm[31:12]; imm[11:0]!=0 -> alignment error.
  - B (101): inst[31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; legal iff imm[31:12] all equal; imm[0]!=0 -> alignment error.
  - J (111): inst[31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]; legal iff imm[31:20] all equal; imm[0]!=0 -> alignment error.
  - Range error takes priority over alignment error.
  - Round-trip invariant: for any legal request, the immediate extender applied to the output with the same immSrc returns i_imm.
- FSM: IDLE, WRITE, FULL.
  - IDLE: o_ready=1. On accept of a legal request: register word, o_memWe=1 next cycle, go WRITE.
  - On accept of an illegal request: request consumed, no write, o_err set, o_errCode written only if o_err was 0, stay IDLE.
  - WRITE: o_ready=0; o_memWe, o_memAddr and o_memWdata held stable until i_memReady.
  - On i_memReady: o_memWe=0 next cycle, o_memAddr+=4, o_count+=1. If the new count equals DEPTH go FULL (o_full=1), else IDLE.
  - Throughput: 1 word per 2 cycles with i_memReady tied high.
  - FULL: o_ready=0; requests ignored until i_start or i_rst.
- i_start, any state, priority over everything except i_rst:
  - Pending write abandoned, o_memWe=0 next cycle.
  - Address reloaded to BASE_ADDR; count, o_full, o_err and o_errCode cleared; go IDLE.
  - A request presented in the same cycle as i_start is not accepted.
- o_memAddr wraps modulo 2^32. o_count never exceeds DEPTH.
- i_rst mid-WRITE: write dropped, o_memWe=0 next cycle.

Decomposition:
- Shared package:
  - immSrc codes (IMM_I_LOAD, IMM_I_ALU, IMM_I_SHAMT, IMM_S, IMM_U, IMM_B, IMM_I_JALR, IMM_J), shared with the immediate extender and decoder.
  - Error codes ERR_NONE/ERR_RANGE/ERR_ALIGN.
  - State enum.
- One combinational sub-module, imm_pack: (immSrc, imm, base) -> (inst, errCode). The FSM, address counter and memory handshake stay in the top module.

Test Plan:
- immSrc=001, base=0x00000093, imm=0xFFFFFFFF, memReady=1 -> write addr 0x0, wdata 0xFFF00093; o_count=1; second write goes to addr 0x4.
- immSrc=101, base=0x00000063, imm=0xFFFFFFFC -> wdata 0xFE000EE3. immSrc=111, base=0x0000006F, imm=8 -> wdata 0x0080006F.
- immSrc=100, base=0x000002B7, imm=0x12345000 -> 0x123452B7. Then imm=0x12345001 -> no write, o_err=1, o_errCode=10. Then I-type imm=0x800 -> no write, code stays 10.
- memReady held low 5 cycles in WRITE -> o_memWe, addr and data stable, o_ready=0; write completes on the cycle memReady rises.
- DEPTH=4, 4 legal writes -> o_full=1, o_ready=0, a fifth request is not written. i_start -> addr=BASE_ADDR, count=0, o_full=0.
- i_start asserted during WRITE with memReady low -> o_memWe=0 next cycle, count unchanged at 0. Repeat with i_rst -> all outputs at reset values.
- Random legal requests across all 8 formats -> immediate extender applied to the output equals i_imm.
